// File: rtl/rpsc_on_sequencer.sv
// -----------------------------------------------------------------------------
// rpsc_on_sequencer
//   Four-stage power-on sequencer (FAN, CA, G1, Anode). Stages are enabled
//   strictly in order 0..3. Each enable waits for its supply feedback, then
//   dwells for a settle period before the next stage is considered. Dropping a
//   request ramps the stages down highest first, one per settle period. A lost
//   permissive, a lost feedback or a feedback timeout trips the sequencer into
//   FAULT, which is left only by fault_clr with all requests low.
//
// Parameters
//   TIMEOUT_CYC  max cycles a new stage may wait for feedback (1 .. 2^CNT_W-1)
//   SETTLE_CYC   dwell after confirmation / per ramp-down step (1 .. 2^CNT_W-1)
//   CNT_W        timer width
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   req[3:0]     latched ON requests   (bit0 FAN, bit1 CA, bit2 G1, bit3 Anode)
//   perm[3:0]    latched ON permissives
//   fb[3:0]      supply-confirmed feedback
//   fault_clr    fault acknowledge, level sensitive
//   LA_Test      lamp test, only when RPSC_SEQ_LA_TEST_EN is defined
//   en[3:0]      registered stage enables
//   level[2:0]   stages enabled or being enabled (0..4)
//   ready        all four stages up and holding
//   seq_fault    sequencer in FAULT (or lamp test active)
//   fault_code   0 none, 1 permissive lost, 2 feedback lost, 3 timeout
//   fault_stage  lowest offending stage index
//
// Build option
//   RPSC_SEQ_LA_TEST_EN  adds LA_Test; while high seq_fault reads 1 without
//                        touching state, enables or fault_code.
// -----------------------------------------------------------------------------
module rpsc_on_sequencer #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int SETTLE_CYC  = 100,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] perm,
  input  logic [3:0] fb,
  input  logic       fault_clr,
`ifdef RPSC_SEQ_LA_TEST_EN
  input  logic       LA_Test,
`endif
  output logic [3:0] en,
  output logic [2:0] level,
  output logic       ready,
  output logic       seq_fault,
  output logic [1:0] fault_code,
  output logic [1:0] fault_stage
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_HOLD   = 3'd3,
    S_DOWN   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] LP_ST_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t           r_state;
  logic [3:0]       r_en;
  logic [2:0]       r_level;
  logic             r_ready;
  logic             r_fault;
  logic [1:0]       r_fault_code;
  logic [1:0]       r_fault_stage;
  logic [CNT_W-1:0] r_timer;

  logic [2:0]       w_lvl_m1;
  logic [2:0]       w_lvl_m2;
  logic [1:0]       w_cur;      // highest enabled stage (level-1)
  logic [1:0]       w_prev;     // stage below it (level-2)
  logic [1:0]       w_nxt;      // next stage to enable (level)
  logic [3:0]       w_confirmed;
  logic [3:0]       w_perm_lost;
  logic [3:0]       w_fb_lost;
  logic             w_timeout;
  logic             w_trip;
  logic [1:0]       w_trip_code;
  logic [1:0]       w_trip_stage;
  logic             w_drop_cur;
  logic             w_drop_below;
  logic             w_timer_sat;

  function automatic logic [1:0] f_lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Mask of stages 0..k-1.
  function automatic logic [3:0] f_below(input logic [2:0] k);
    case (k)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    w_lvl_m1 = r_level - 3'd1;
    w_lvl_m2 = r_level - 3'd2;
    w_cur    = w_lvl_m1[1:0];
    w_prev   = w_lvl_m2[1:0];
    w_nxt    = r_level[1:0];

    // In WAIT the newest stage is not confirmed yet; everywhere else every
    // set enable has already seen its feedback.
    w_confirmed = 4'b0000;
    case (r_state)
      S_WAIT:                   w_confirmed = r_en & ~(4'b0001 << w_cur);
      S_SETTLE, S_HOLD, S_DOWN: w_confirmed = r_en;
      default:                  w_confirmed = 4'b0000;
    endcase

    w_perm_lost = r_en & ~perm;
    w_fb_lost   = w_confirmed & ~fb;
    w_timeout   = (r_state == S_WAIT) && !fb[w_cur] && (r_timer >= LP_TO_LAST);

    w_trip       = 1'b0;
    w_trip_code  = 2'd0;
    w_trip_stage = 2'd0;
    if (|w_perm_lost) begin
      w_trip       = 1'b1;
      w_trip_code  = 2'd1;
      w_trip_stage = f_lowest(w_perm_lost);
    end else if (|w_fb_lost) begin
      w_trip       = 1'b1;
      w_trip_code  = 2'd2;
      w_trip_stage = f_lowest(w_fb_lost);
    end else if (w_timeout) begin
      w_trip       = 1'b1;
      w_trip_code  = 2'd3;
      w_trip_stage = w_cur;
    end

    w_drop_cur   = |(f_below(r_level)  & ~req);
    w_drop_below = |(f_below(w_lvl_m1) & ~req);
    w_timer_sat  = &r_timer;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_en          <= 4'b0000;
      r_level       <= 3'd0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= 2'd0;
      r_fault_stage <= 2'd0;
      r_timer       <= '0;
    end else begin
      r_ready <= 1'b0;
      if (w_trip) begin
        // A trip wins over any advance or ramp-down decided this cycle.
        r_state       <= S_FAULT;
        r_en          <= 4'b0000;
        r_level       <= 3'd0;
        r_fault       <= 1'b1;
        r_fault_code  <= w_trip_code;
        r_fault_stage <= w_trip_stage;
        r_timer       <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_HOLD: begin
            if ((r_level != 3'd0) && w_drop_cur) begin
              r_state     <= S_DOWN;
              r_en[w_cur] <= 1'b0;
              r_timer     <= '0;
            end else if ((r_level < 3'd4) && req[w_nxt] && perm[w_nxt]) begin
              r_state     <= S_WAIT;
              r_level     <= r_level + 3'd1;
              r_en[w_nxt] <= 1'b1;
              r_timer     <= '0;
            end else begin
              r_ready <= (r_level == 3'd4);
            end
          end
          S_WAIT: begin
            if (fb[w_cur]) begin
              r_state <= S_SETTLE;
              r_timer <= '0;
            end else if (!w_timer_sat) begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_timer >= LP_ST_LAST) begin
              r_state <= S_HOLD;
              r_timer <= '0;
              r_ready <= (r_level == 3'd4);
            end else if (!w_timer_sat) begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_DOWN: begin
            if (r_timer >= LP_ST_LAST) begin
              r_level <= w_lvl_m1;
              r_timer <= '0;
              // Chain straight into the next step so each stage drops one
              // settle period after the previous one.
              if ((w_lvl_m1 != 3'd0) && w_drop_below) begin
                r_en[w_prev] <= 1'b0;
              end else begin
                r_state <= (w_lvl_m1 == 3'd0) ? S_IDLE : S_HOLD;
              end
            end else if (!w_timer_sat) begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_FAULT: begin
            if (fault_clr && (req == 4'b0000)) begin
              r_state       <= S_IDLE;
              r_fault       <= 1'b0;
              r_fault_code  <= 2'd0;
              r_fault_stage <= 2'd0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_en    <= 4'b0000;
            r_level <= 3'd0;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

  assign en          = r_en;
  assign level       = r_level;
  assign ready       = r_ready;
  assign fault_code  = r_fault_code;
  assign fault_stage = r_fault_stage;
`ifdef RPSC_SEQ_LA_TEST_EN
  assign seq_fault   = r_fault | LA_Test;
`else
  assign seq_fault   = r_fault;
`endif

endmodule

// File: tb/tb_rpsc_on_sequencer.sv
module tb_rpsc_on_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] perm;
  logic [3:0] fb;
  logic       fault_clr;
`ifdef RPSC_SEQ_LA_TEST_EN
  logic       LA_Test;
`endif
  logic [3:0] en;
  logic [2:0] level;
  logic       ready;
  logic       seq_fault;
  logic [1:0] fault_code;
  logic [1:0] fault_stage;

  rpsc_on_sequencer #(.TIMEOUT_CYC(8), .SETTLE_CYC(4), .CNT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .perm(perm),
    .fb(fb),
    .fault_clr(fault_clr),
`ifdef RPSC_SEQ_LA_TEST_EN
    .LA_Test(LA_Test),
`endif
    .en(en),
    .level(level),
    .ready(ready),
    .seq_fault(seq_fault),
    .fault_code(fault_code),
    .fault_stage(fault_stage)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] en;
    logic [2:0] lvl;
    logic       rdy;
    logic       sf;
    logic [1:0] code;
    logic [1:0] stg;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
    string nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Supply model: feedback follows the enables two cycles later; kill forces bits low.
  logic [3:0] fb_d1 = 4'b0;
  logic [3:0] fb_d2 = 4'b0;
  logic [3:0] kill  = 4'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    fb_d1 <= en;
    fb_d2 <= fb_d1;
  end
  assign fb = fb_d2 & ~kill;

  task automatic push(input int c, input logic [3:0] e, input logic [2:0] l,
                      input logic r, input logic sf, input logic [1:0] cd,
                      input logic [1:0] st, input string nm);
    exp_t x;
    x.s   = {e, l, r, sf, cd, st};
    x.cyc = c;
    x.nm  = nm;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    snap_t cur;
    cur = {en, level, ready, seq_fault, fault_code, fault_stage};
    checks++;
    if (cur != '0) begin
      errors++;
      $display("FAIL %s: got outputs %h, need 0", nm, cur);
    end
  endtask

  // Monitor: every change of the output bundle consumes one expected entry.
  initial begin : monitor
    snap_t cur;
    snap_t prev;
    exp_t  x;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {en, level, ready, seq_fault, fault_code, fault_stage};
      if (cur != prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change at cyc %0d: got %h, need no change", cyc, cur);
        end else begin
          x = q.pop_front();
          checks += 2;
          if (cur != x.s) begin
            errors++;
            $display("FAIL %s: got en=%h lvl=%0d rdy=%b sf=%b code=%0d stg=%0d, need en=%h lvl=%0d rdy=%b sf=%b code=%0d stg=%0d",
                     x.nm, cur.en, cur.lvl, cur.rdy, cur.sf, cur.code, cur.stg,
                     x.s.en, x.s.lvl, x.s.rdy, x.s.sf, x.s.code, x.s.stg);
          end
          if (cyc != x.cyc) begin
            errors++;
            $display("FAIL %s_cycle: got cycle %0d, need %0d", x.nm, cyc, x.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end by 100000ns, need finish");
    $fatal(1);
  end

  task automatic ramp_up_expect(input int b, input string tag);
    push(b + 1,  4'h1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, {tag, "_en1"});
    push(b + 9,  4'h3, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, {tag, "_en3"});
    push(b + 17, 4'h7, 3'd3, 1'b0, 1'b0, 2'd0, 2'd0, {tag, "_en7"});
    push(b + 25, 4'hF, 3'd4, 1'b0, 1'b0, 2'd0, 2'd0, {tag, "_enF"});
    push(b + 32, 4'hF, 3'd4, 1'b1, 1'b0, 2'd0, 2'd0, {tag, "_ready"});
  endtask

  initial begin : stim
    int b;
    reset     = 1'b1;
    req       = 4'h0;
    perm      = 4'hF;
    fault_clr = 1'b0;
`ifdef RPSC_SEQ_LA_TEST_EN
    LA_Test   = 1'b0;
`endif
    #1 reset = 1'b0;
    repeat (3) step();
    check_zero("reset_state");
    reset = 1'b1;
    repeat (2) step();

    // Full ramp-up: 1,3,7,F then ready.
    step(); b = cyc; req = 4'hF;
    ramp_up_expect(b, "up");
    repeat (36) step();

    // Ramp-down, one stage every 4 cycles.
    step(); b = cyc; req = 4'h0;
    push(b + 1,  4'h7, 3'd4, 1'b0, 1'b0, 2'd0, 2'd0, "down_en7");
    push(b + 5,  4'h3, 3'd3, 1'b0, 1'b0, 2'd0, 2'd0, "down_en3");
    push(b + 9,  4'h1, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, "down_en1");
    push(b + 13, 4'h0, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, "down_en0");
    push(b + 17, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, "down_lvl0");
    repeat (22) step();

    // Stage 1 feedback never arrives: timeout after 8 WAIT cycles.
    kill = 4'h2;
    step(); b = cyc; req = 4'hF;
    push(b + 1,  4'h1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, "to_en1");
    push(b + 9,  4'h3, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, "to_en3");
    push(b + 17, 4'h0, 3'd0, 1'b0, 1'b1, 2'd3, 2'd1, "to_fault");
    repeat (20) step();
    b = cyc; req = 4'h0; fault_clr = 1'b1;
    push(b + 1,  4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, "to_clear");
    repeat (2) step();
    fault_clr = 1'b0; kill = 4'h0;
    repeat (4) step();

    // Permissive 2 and feedback 0 lost together: permissive wins.
    step(); b = cyc; req = 4'hF;
    ramp_up_expect(b, "trip");
    repeat (36) step();
    b = cyc; perm = 4'hB; kill = 4'h1;
    push(b + 1,  4'h0, 3'd0, 1'b0, 1'b1, 2'd1, 2'd2, "trip_fault");
    repeat (3) step();
    perm = 4'hF; kill = 4'h0; fault_clr = 1'b1;
    repeat (4) step();
    b = cyc; req = 4'h0;
    push(b + 1,  4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, "trip_clear");
    step();
    fault_clr = 1'b0;
    repeat (4) step();

    // Reset asserted mid-SETTLE at level 2.
    step(); b = cyc; req = 4'hF;
    push(b + 1,  4'h1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, "rst_en1");
    push(b + 9,  4'h3, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, "rst_en3");
    repeat (10) step();
`ifdef RPSC_SEQ_LA_TEST_EN
    LA_Test = 1'b1;
    push(b + 10, 4'h3, 3'd2, 1'b0, 1'b1, 2'd0, 2'd0, "lamp_on");
`endif
    repeat (2) step();
`ifdef RPSC_SEQ_LA_TEST_EN
    LA_Test = 1'b0;
    push(b + 12, 4'h3, 3'd2, 1'b0, 1'b0, 2'd0, 2'd0, "lamp_off");
`endif
    step();
    #1;
    push(b + 13, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, "rst_zero");
    reset = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (3) step();
    req = 4'h0;
    step();
    reset = 1'b1;

    // Resume from IDLE: single stage up, then down again.
    step(); b = cyc; req = 4'h1;
    push(b + 1,  4'h1, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, "resume_en1");
    push(b + 9,  4'h0, 3'd1, 1'b0, 1'b0, 2'd0, 2'd0, "resume_down");
    push(b + 13, 4'h0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, "resume_lvl0");
    step();
    req = 4'h0;
    repeat (18) step();

    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    while (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s_missing: got no output change, need change at cycle %0d", x.nm, x.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
